// File: rtl/dm_bus_arbiter_if.sv
// Requester-side bundle for one master of the shared data-memory bus.
// The arbiter takes the slave view; a CPU or DMA engine takes the master view.
interface dm_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          rd;
  logic          wr;
  logic          lock;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic          ack;
  logic          err;

  modport master (output req, rd, wr, lock, addr, din, input ack, err);
  modport slave  (input req, rd, wr, lock, addr, din, output ack, err);
endinterface

// File: rtl/dm_bus_arbiter.sv
// Round-robin two-master arbiter for the data-memory bus (port 0 = CPU, port 1 = DMA),
// with programmable wait states, one-cycle ack, protocol-error reporting and bus lock.
module dm_bus_arbiter #(
  parameter int WAIT_STATES = 1,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input  logic                clk,
  input  logic                reset,
  dm_bus_arbiter_if.slave     p0,
  dm_bus_arbiter_if.slave     p1,
  output logic                gnt,
  output logic [DW-1:0]       dout,
  output logic                m_cs,
  output logic                m_rd,
  output logic                m_wr,
  output logic [AW-1:0]       m_addr,
  output logic [DW-1:0]       m_din,
  input  logic [DW-1:0]       m_dout
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_ACK    = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

  logic [1:0]    state_q,  state_d;
  logic [3:0]    cnt_q,    cnt_d;
  logic          gnt_q,    gnt_d;
  logic          lock_q,   lock_d;
  logic          err_q,    err_d;
  logic          m_cs_q,   m_cs_d;
  logic          m_rd_q,   m_rd_d;
  logic          m_wr_q,   m_wr_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_din_q,  m_din_d;
  logic [DW-1:0] dout_q,   dout_d;

  logic          win;
  logic          sel_req, sel_rd, sel_wr, sel_lock;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_din;
  logic          do_latch;

  // In IDLE a tie goes to the port that did not own the bus last; in ACK only
  // the current owner may re-latch (locked sequence).
  always_comb begin
    win = gnt_q;
    if (state_q == S_IDLE) begin
      win = (p0.req && p1.req) ? ~gnt_q : p1.req;
    end
    sel_req  = win ? p1.req  : p0.req;
    sel_rd   = win ? p1.rd   : p0.rd;
    sel_wr   = win ? p1.wr   : p0.wr;
    sel_lock = win ? p1.lock : p0.lock;
    sel_addr = win ? p1.addr : p0.addr;
    sel_din  = win ? p1.din  : p0.din;
    do_latch = ((state_q == S_IDLE) && (p0.req || p1.req)) ||
               ((state_q == S_ACK) && lock_q && sel_req);
  end

  always_comb begin
    // NOTE: every *_d gets its hold value first so no path through this block infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    lock_d   = lock_q;
    err_d    = err_q;
    m_cs_d   = m_cs_q;
    m_rd_d   = m_rd_q;
    m_wr_d   = m_wr_q;
    m_addr_d = m_addr_q;
    m_din_d  = m_din_q;
    dout_d   = dout_q;

    case (state_q)
      S_IDLE: ;
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = S_ACK;
          m_cs_d  = 1'b0;
          m_rd_d  = 1'b0;
          m_wr_d  = 1'b0;
          if (m_rd_q) dout_d = m_dout;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A rd==wr command still runs the full access timing but with both strobes low.
    if (do_latch) begin
      state_d  = S_ACCESS;
      cnt_d    = CNT_INIT;
      gnt_d    = win;
      lock_d   = sel_lock;
      err_d    = (sel_rd == sel_wr);
      m_cs_d   = 1'b1;
      m_rd_d   = sel_rd && !sel_wr;
      m_wr_d   = sel_wr && !sel_rd;
      m_addr_d = sel_addr;
      m_din_d  = sel_din;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      gnt_q    <= 1'b1;
      lock_q   <= 1'b0;
      err_q    <= 1'b0;
      m_cs_q   <= 1'b0;
      m_rd_q   <= 1'b0;
      m_wr_q   <= 1'b0;
      m_addr_q <= '0;
      m_din_q  <= '0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      lock_q   <= lock_d;
      err_q    <= err_d;
      m_cs_q   <= m_cs_d;
      m_rd_q   <= m_rd_d;
      m_wr_q   <= m_wr_d;
      m_addr_q <= m_addr_d;
      m_din_q  <= m_din_d;
      dout_q   <= dout_d;
    end
  end

  assign p0.ack = (state_q == S_ACK) && !gnt_q;
  assign p1.ack = (state_q == S_ACK) &&  gnt_q;
  assign p0.err = p0.ack && err_q;
  assign p1.err = p1.ack && err_q;

  assign gnt    = gnt_q;
  assign dout   = dout_q;
  assign m_cs   = m_cs_q;
  assign m_rd   = m_rd_q;
  assign m_wr   = m_wr_q;
  assign m_addr = m_addr_q;
  assign m_din  = m_din_q;

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Directed bench for dm_bus_arbiter: one instance with 1 wait state, one with 3,
// each in front of a small word-addressed memory model.
module tb_dm_bus_arbiter;

  logic clk;
  logic reset;

  dm_bus_arbiter_if #(.AW(32), .DW(32)) a0 ();
  dm_bus_arbiter_if #(.AW(32), .DW(32)) a1 ();
  dm_bus_arbiter_if #(.AW(32), .DW(32)) b0 ();
  dm_bus_arbiter_if #(.AW(32), .DW(32)) b1 ();

  logic        u1_gnt, u1_m_cs, u1_m_rd, u1_m_wr;
  logic [31:0] u1_dout, u1_m_addr, u1_m_din, u1_m_dout;
  logic        u3_gnt, u3_m_cs, u3_m_rd, u3_m_wr;
  logic [31:0] u3_dout, u3_m_addr, u3_m_din, u3_m_dout;

  logic [31:0] mem1 [64] = '{4: 32'hDEADBEEF, default: 32'h0};
  logic [31:0] mem3 [64] = '{default: 32'h0};

  int total;
  int passed;

  dm_bus_arbiter #(.WAIT_STATES(1), .AW(32), .DW(32)) u1 (
    .clk(clk), .reset(reset), .p0(a0), .p1(a1), .gnt(u1_gnt), .dout(u1_dout),
    .m_cs(u1_m_cs), .m_rd(u1_m_rd), .m_wr(u1_m_wr), .m_addr(u1_m_addr),
    .m_din(u1_m_din), .m_dout(u1_m_dout)
  );

  dm_bus_arbiter #(.WAIT_STATES(3), .AW(32), .DW(32)) u3 (
    .clk(clk), .reset(reset), .p0(b0), .p1(b1), .gnt(u3_gnt), .dout(u3_dout),
    .m_cs(u3_m_cs), .m_rd(u3_m_rd), .m_wr(u3_m_wr), .m_addr(u3_m_addr),
    .m_din(u3_m_din), .m_dout(u3_m_dout)
  );

  assign u1_m_dout = (u1_m_cs && u1_m_rd) ? mem1[u1_m_addr[7:2]] : 32'h0;
  assign u3_m_dout = (u3_m_cs && u3_m_rd) ? mem3[u3_m_addr[7:2]] : 32'h0;

  always @(posedge clk) begin
    if (u1_m_cs && u1_m_wr) mem1[u1_m_addr[7:2]] <= u1_m_din;
    if (u3_m_cs && u3_m_wr) mem3[u3_m_addr[7:2]] <= u3_m_din;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic clear_ports();
    a0.req = 0; a0.rd = 0; a0.wr = 0; a0.lock = 0; a0.addr = '0; a0.din = '0;
    a1.req = 0; a1.rd = 0; a1.wr = 0; a1.lock = 0; a1.addr = '0; a1.din = '0;
    b0.req = 0; b0.rd = 0; b0.wr = 0; b0.lock = 0; b0.addr = '0; b0.din = '0;
    b1.req = 0; b1.rd = 0; b1.wr = 0; b1.lock = 0; b1.addr = '0; b1.din = '0;
  endtask

  initial begin
    int n, cyc, idx, wr_n, last_wr, unstable, ack0_n, ack1_n, ack1_at, viol, first_after, ack_at;
    int order [4];
    int when_c [4];
    int gnt_at [4];

    total = 0;
    passed = 0;
    clear_ports();
    reset = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_m_cs",   u1_m_cs,   1'b0);
    check("rst_m_addr", u1_m_addr, 32'h0);
    check("rst_dout",   u1_dout,   32'h0);
    check("rst_gnt",    u1_gnt,    1'b1);
    check("rst_ack0",   a0.ack,    1'b0);
    check("rst_gnt_u3", u3_gnt,    1'b1);

    // Single CPU read, 1 wait state
    reset = 1'b1;
    a0.req = 1; a0.rd = 1; a0.addr = 32'h10;
    @(negedge clk);
    check("t1_cs",   u1_m_cs,   1'b1);
    check("t1_rd",   u1_m_rd,   1'b1);
    check("t1_wr",   u1_m_wr,   1'b0);
    check("t1_addr", u1_m_addr, 32'h10);
    check("t1_gnt",  u1_gnt,    1'b0);
    check("t1_noack", a0.ack,   1'b0);
    @(negedge clk);
    check("t1_ack0", a0.ack,   1'b1);
    check("t1_ack1", a1.ack,   1'b0);
    check("t1_cs_off", u1_m_cs, 1'b0);
    check("t1_dout", u1_dout,  32'hDEADBEEF);
    a0.req = 0; a0.rd = 0;
    @(negedge clk);
    check("t1_ack_pulse", a0.ack, 1'b0);

    // Both masters writing continuously: round-robin, 3-cycle ack spacing
    a0.req = 1; a0.wr = 1; a0.addr = 32'h20; a0.din = 32'hA0A0A0A0;
    a1.req = 1; a1.wr = 1; a1.addr = 32'h24; a1.din = 32'hB1B1B1B1;
    n = 0; cyc = 0;
    for (int i = 0; i < 20 && n < 4; i++) begin
      @(negedge clk);
      cyc++;
      if (a0.ack || a1.ack) begin
        order[n]  = a1.ack ? 1 : 0;
        when_c[n] = cyc;
        gnt_at[n] = u1_gnt ? 1 : 0;
        n++;
        if (a0.ack && a1.ack) check("t2_dual_ack", 1'b1, 1'b0);
      end
    end
    a0.req = 0; a0.wr = 0; a1.req = 0; a1.wr = 0;
    check("t2_ack_count", n, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2_order%0d", k), order[k],  (k % 2 == 0) ? 1 : 0);
      check($sformatf("t2_gnt%0d", k),   gnt_at[k], (k % 2 == 0) ? 1 : 0);
      if (k > 0) check($sformatf("t2_gap%0d", k), when_c[k] - when_c[k-1], 3);
    end
    check("t2_mem20", mem1[8], 32'hA0A0A0A0);
    check("t2_mem24", mem1[9], 32'hB1B1B1B1);
    @(negedge clk);

    // 3 wait states, DMA write
    b1.req = 1; b1.wr = 1; b1.addr = 32'h30; b1.din = 32'h12345678;
    idx = 0; wr_n = 0; last_wr = 0; unstable = 0; ack0_n = 0; ack1_n = 0; ack1_at = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      idx++;
      if (u3_m_wr) begin
        wr_n++;
        last_wr = idx;
        if (u3_m_addr !== 32'h30 || u3_m_din !== 32'h12345678 || !u3_m_cs) unstable++;
      end
      if (b0.ack) ack0_n++;
      if (b1.ack) begin
        ack1_n++;
        ack1_at = idx;
        b1.req = 0; b1.wr = 0;
      end
    end
    check("t3_wr_cycles", wr_n,     3);
    check("t3_unstable",  unstable, 0);
    check("t3_ack1_n",    ack1_n,   1);
    check("t3_ack1_at",   ack1_at,  last_wr + 1);
    check("t3_ack0_n",    ack0_n,   0);
    check("t3_mem30",     mem3[12], 32'h12345678);

    // Locked CPU sequence holds off a requesting DMA
    a0.req = 1; a0.lock = 1; a0.rd = 1; a0.addr = 32'h10;
    @(negedge clk);
    a1.req = 1; a1.wr = 1; a1.addr = 32'h28; a1.din = 32'hC2C2C2C2;
    ack0_n = 0; ack1_n = 0; viol = 0; first_after = -1;
    for (int i = 0; i < 30 && ack1_n == 0; i++) begin
      @(negedge clk);
      if (u1_m_cs && u1_gnt && ack0_n < 3) viol++;
      if (u1_m_cs && ack0_n == 3 && first_after < 0) first_after = u1_gnt ? 1 : 0;
      if (a0.ack) begin
        ack0_n++;
        if (ack0_n == 2) a0.lock = 0;
      end
      if (a1.ack) begin
        ack1_n++;
        a0.req = 0; a0.rd = 0; a1.req = 0; a1.wr = 0;
      end
    end
    check("t4_ack0_n",      ack0_n,      3);
    check("t4_violations",  viol,        0);
    check("t4_next_owner",  first_after, 1);
    check("t4_ack1_n",      ack1_n,      1);
    check("t4_mem28",       mem1[10],    32'hC2C2C2C2);
    check("t4_dout",        u1_dout,     32'hDEADBEEF);
    @(negedge clk);

    // Protocol error: rd and wr both set
    a1.req = 1; a1.rd = 1; a1.wr = 1; a1.addr = 32'h24; a1.din = 32'hFFFFFFFF;
    @(negedge clk);
    check("t5_cs", u1_m_cs, 1'b1);
    check("t5_rd", u1_m_rd, 1'b0);
    check("t5_wr", u1_m_wr, 1'b0);
    @(negedge clk);
    check("t5_ack1", a1.ack, 1'b1);
    check("t5_err1", a1.err, 1'b1);
    check("t5_err0", a0.err, 1'b0);
    check("t5_ack0", a0.ack, 1'b0);
    a1.req = 0; a1.rd = 0; a1.wr = 0;
    check("t5_mem24", mem1[9],  32'hB1B1B1B1);
    check("t5_dout",  u1_dout,  32'hDEADBEEF);
    @(negedge clk);
    check("t5_err_pulse", a1.err, 1'b0);

    // Reset in the middle of a 3-wait-state write
    b0.req = 1; b0.wr = 1; b0.addr = 32'h40; b0.din = 32'h55;
    @(negedge clk);
    check("t6_cs_first", u3_m_cs, 1'b1);
    @(negedge clk);
    check("t6_wr_mid", u3_m_wr, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("t6_cs_async", u3_m_cs, 1'b0);
    check("t6_wr_async", u3_m_wr, 1'b0);
    @(negedge clk);
    check("t6_no_ack", b0.ack, 1'b0);
    check("t6_gnt_rst", u3_gnt, 1'b1);
    b0.req = 0; b0.wr = 0;
    reset = 1'b1;
    b0.req = 1; b0.rd = 1; b0.addr = 32'h30;
    idx = 0; ack_at = 0;
    for (int i = 0; i < 10 && ack_at == 0; i++) begin
      @(negedge clk);
      idx++;
      if (b0.ack) ack_at = idx;
    end
    b0.req = 0; b0.rd = 0;
    check("t6_ack_latency", ack_at,  4);
    check("t6_dout",        u3_dout, 32'h12345678);
    check("t6_gnt",         u3_gnt,  1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
